playback_addr_ctrl: RTL and testbench

PLAYBACK_ADDR_CTRL -- requirements
Module: playback_addr_ctrl

---
 rtl/playback_addr_ctrl_if.sv | 31 +++
 rtl/playback_addr_ctrl.sv | 169 ++++++++++++++++
 tb/tb_playback_addr_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/playback_addr_ctrl_if.sv
// Command/status bundle of the sample-playback address controller.
// The controller sits on the slave side; whoever issues commands and
// consumes the address is the master.
interface playback_addr_ctrl_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned STEP_W = 4
);
  logic              tick;
  logic              cmd_play;
  logic              cmd_pause;
  logic              cmd_fwd;
  logic              cmd_bwd;
  logic              cmd_restart;
  logic              loop_en;
  logic [STEP_W-1:0] step;
  logic [ADDR_W-1:0] addr;
  logic              playing;
  logic              dir;
  logic              wrapped;
  logic              done;

  modport master (
    output tick, cmd_play, cmd_pause, cmd_fwd, cmd_bwd, cmd_restart, loop_en, step,
    input  addr, playing, dir, wrapped, done
  );

  modport slave (
    input  tick, cmd_play, cmd_pause, cmd_fwd, cmd_bwd, cmd_restart, loop_en, step,
    output addr, playing, dir, wrapped, done
  );
endinterface

// File: rtl/playback_addr_ctrl.sv
// Sample-playback address controller.
// Walks an address between ADDR_MIN and ADDR_MAX, forward or backward, by a
// programmable step on every sample tick. Commands are levels sampled each
// clock; the highest-priority asserted command is the one evaluated. A
// command that actually changes something consumes the cycle, so a tick in
// that cycle does not advance the address. At a bound the address either
// wraps (loop) or clamps and the controller parks in DONE (one-shot).
module playback_addr_ctrl #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned ADDR_MIN = 0,
  parameter int unsigned ADDR_MAX = 'h7FFFF,
  parameter int unsigned STEP_W   = 4
) (
  input logic                clk,
  input logic                reset,
  playback_addr_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] MIN_A = ADDR_W'(ADDR_MIN);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W:0]   MAX_X = (ADDR_W + 1)'(ADDR_MAX);

  typedef enum logic [2:0] {
    IDLE_FW = 3'd0,
    IDLE_BW = 3'd1,
    PLAY_FW = 3'd2,
    PLAY_BW = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              playing_q, playing_d;
  logic              wrapped_q, wrapped_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   step_s;
  logic [ADDR_W:0]   sum_s;
  logic [ADDR_W-1:0] diff_s;
  logic [ADDR_W+1:0] lo_lim_s;
  logic              fw_over_s;
  logic              bw_under_s;
  logic              is_play_s;
  logic              cmd_taken_s;
  logic [ADDR_W-1:0] start_s;

  function automatic state_t idle_of(input logic d);
    return d ? IDLE_BW : IDLE_FW;
  endfunction

  function automatic state_t play_of(input logic d);
    return d ? PLAY_BW : PLAY_FW;
  endfunction

  // Step arithmetic and bound detection; one bit of headroom keeps the overflow visible.
  always_comb begin
    if (bus.step == '0) begin
      step_s = {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      step_s = (ADDR_W + 1)'(bus.step);
    end
    sum_s      = {1'b0, addr_q} + step_s;
    diff_s     = addr_q - step_s[ADDR_W-1:0];
    lo_lim_s   = {2'b00, MIN_A} + {1'b0, step_s};
    fw_over_s  = (sum_s > MAX_X);
    bw_under_s = ({2'b00, addr_q} < lo_lim_s);
    is_play_s  = (state_q == PLAY_FW) || (state_q == PLAY_BW);
    start_s    = dir_q ? MAX_A : MIN_A;
  end

  // Next-state: resolve the command first, then advance on tick if no command took effect.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dir_d       = dir_q;
    wrapped_d   = 1'b0;
    done_d      = 1'b0;
    cmd_taken_s = 1'b0;

    if (bus.cmd_restart) begin
      cmd_taken_s = 1'b1;
      addr_d      = start_s;
      if (state_q == DONE) begin
        state_d = idle_of(dir_q);
      end else begin
        state_d = state_q;
      end
    end else if (bus.cmd_fwd || bus.cmd_bwd) begin
      cmd_taken_s = 1'b1;
      dir_d       = ~bus.cmd_fwd;
      if (is_play_s) begin
        state_d = play_of(dir_d);
      end else begin
        state_d = idle_of(dir_d);
      end
    end else if (bus.cmd_pause && is_play_s) begin
      cmd_taken_s = 1'b1;
      state_d     = idle_of(dir_q);
    end else if (bus.cmd_play && !bus.cmd_pause && !is_play_s) begin
      // A pause that is a no-op still outranks play in the same cycle.
      cmd_taken_s = 1'b1;
      state_d     = play_of(dir_q);
      if (state_q == DONE) begin
        addr_d = start_s;
      end else begin
        addr_d = addr_q;
      end
    end else begin
      cmd_taken_s = 1'b0;
    end

    if (!cmd_taken_s && bus.tick && is_play_s) begin
      if (!dir_q) begin
        if (!fw_over_s) begin
          addr_d = sum_s[ADDR_W-1:0];
        end else if (bus.loop_en) begin
          addr_d    = MIN_A;
          wrapped_d = 1'b1;
        end else begin
          addr_d  = MAX_A;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        if (!bw_under_s) begin
          addr_d = diff_s;
        end else if (bus.loop_en) begin
          addr_d    = MAX_A;
          wrapped_d = 1'b1;
        end else begin
          addr_d  = MIN_A;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end else begin
      wrapped_d = 1'b0;
    end

    playing_d = (state_d == PLAY_FW) || (state_d == PLAY_BW);
  end

  // State and output registers; reset parks the controller at the forward start bound.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE_FW;
      addr_q    <= MIN_A;
      dir_q     <= 1'b0;
      playing_q <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dir_q     <= dir_d;
      playing_q <= playing_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.playing = playing_q;
  assign bus.dir     = dir_q;
  assign bus.wrapped = wrapped_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_playback_addr_ctrl.sv
// Bench for playback_addr_ctrl: directed vector table on a 0..15 instance,
// plus random stimulus on that instance and on a 5..27 instance, each
// checked against a behavioural model of the playback rules.
module tb_playback_addr_ctrl;

  localparam int AW = 8;
  localparam int SW = 4;
  localparam int LO_A = 0;
  localparam int HI_A = 15;
  localparam int LO_B = 5;
  localparam int HI_B = 27;

  logic clk = 1'b0;
  logic reset;
  logic tick, c_play, c_pause, c_fwd, c_bwd, c_rst, loop_en;
  logic [SW-1:0] step;

  playback_addr_ctrl_if #(.ADDR_W(AW), .STEP_W(SW)) if_a ();
  playback_addr_ctrl_if #(.ADDR_W(AW), .STEP_W(SW)) if_b ();

  assign if_a.tick = tick;        assign if_b.tick = tick;
  assign if_a.cmd_play = c_play;  assign if_b.cmd_play = c_play;
  assign if_a.cmd_pause = c_pause; assign if_b.cmd_pause = c_pause;
  assign if_a.cmd_fwd = c_fwd;    assign if_b.cmd_fwd = c_fwd;
  assign if_a.cmd_bwd = c_bwd;    assign if_b.cmd_bwd = c_bwd;
  assign if_a.cmd_restart = c_rst; assign if_b.cmd_restart = c_rst;
  assign if_a.loop_en = loop_en;  assign if_b.loop_en = loop_en;
  assign if_a.step = step;        assign if_b.step = step;

  playback_addr_ctrl #(.ADDR_W(AW), .ADDR_MIN(LO_A), .ADDR_MAX(HI_A), .STEP_W(SW)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  playback_addr_ctrl #(.ADDR_W(AW), .ADDR_MIN(LO_B), .ADDR_MAX(HI_B), .STEP_W(SW)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  always #5 clk = ~clk;

  logic [11:0] out_a, out_b;
  assign out_a = {if_a.addr, if_a.playing, if_a.dir, if_a.wrapped, if_a.done};
  assign out_b = {if_b.addr, if_b.playing, if_b.dir, if_b.wrapped, if_b.done};

  // Behavioural model: playing / finished flags plus an integer address.
  typedef struct {
    int addr;
    bit dir;
    bit play;
    bit fin;
    bit wrapped;
    bit done;
  } mdl_t;

  typedef struct {
    bit tk, rs, fw, bw, pa, pl, lp;
    int st;
    int ea;
    bit ep, ed, ew, edn;
  } vec_t;

  mdl_t mdl_a, mdl_b;
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic mdl_t mdl_rst(input int lo);
    mdl_t m;
    m.addr = lo; m.dir = 1'b0; m.play = 1'b0; m.fin = 1'b0;
    m.wrapped = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  function automatic mdl_t ref_next(input mdl_t m, input int lo, input int hi,
                                    input bit tk, rs, fw, bw, pa, pl, lp, input int st);
    mdl_t n;
    bit   busy;
    int   start, s, nxt;
    n = m; n.wrapped = 1'b0; n.done = 1'b0;
    busy  = 1'b0;
    start = m.dir ? hi : lo;
    if (rs) begin
      n.addr = start; n.fin = 1'b0; busy = 1'b1;
    end else if (fw || bw) begin
      n.dir = fw ? 1'b0 : 1'b1; n.fin = 1'b0; busy = 1'b1;
    end else if (pa) begin
      if (m.play) begin n.play = 1'b0; busy = 1'b1; end
    end else if (pl) begin
      if (!m.play) begin
        n.play = 1'b1; busy = 1'b1;
        if (m.fin) begin n.fin = 1'b0; n.addr = start; end
      end
    end
    if (!busy && tk && m.play) begin
      s   = (st == 0) ? 1 : st;
      nxt = m.dir ? m.addr - s : m.addr + s;
      if (nxt > hi || nxt < lo) begin
        if (lp) begin
          n.addr = m.dir ? hi : lo; n.wrapped = 1'b1;
        end else begin
          n.addr = m.dir ? lo : hi; n.play = 1'b0; n.fin = 1'b1; n.done = 1'b1;
        end
      end else begin
        n.addr = nxt;
      end
    end
    return n;
  endfunction

  function automatic logic [11:0] pk(input mdl_t m);
    return {AW'(m.addr), m.play, m.dir, m.wrapped, m.done};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: actual {addr,play,dir,wrap,done}=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input bit tk, rs, fw, bw, pa, pl, lp, input int st,
                     input int ea, input bit ep, ed, ew, edn);
    vec_t v;
    v.tk = tk; v.rs = rs; v.fw = fw; v.bw = bw; v.pa = pa; v.pl = pl; v.lp = lp; v.st = st;
    v.ea = ea; v.ep = ep; v.ed = ed; v.ew = ew; v.edn = edn;
    tbl.push_back(v);
  endtask

  // Called at a falling edge: apply inputs, advance the models, move to the next falling edge.
  task automatic drive(input bit tk, rs, fw, bw, pa, pl, lp, input int st);
    tick = tk; c_rst = rs; c_fwd = fw; c_bwd = bw; c_pause = pa; c_play = pl;
    loop_en = lp; step = SW'(st);
    mdl_a = ref_next(mdl_a, LO_A, HI_A, tk, rs, fw, bw, pa, pl, lp, st);
    mdl_b = ref_next(mdl_b, LO_B, HI_B, tk, rs, fw, bw, pa, pl, lp, st);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //   tk rs fw bw pa pl lp st    addr pl dir wr dn
    add(0, 0, 0, 0, 0, 1, 1, 1,    0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1,    1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1,    2, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1,    3, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1,    4, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0,    5, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 4,    9, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 4,    0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 14,  14, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 3,    0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 3,    0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 15,  15, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1,    0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 7,    7, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 1,    7, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1,    6, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 4,    2, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4,    0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 4,    0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4,    0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 4,   15, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 15,   0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1,    0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 15,  15, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,   15, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 1,    0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1,    0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1,    0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1,    0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1,   15, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 4,   11, 1, 1, 0, 0);

    reset = 1'b1;
    tick = 1'b0; c_play = 1'b0; c_pause = 1'b0; c_fwd = 1'b0; c_bwd = 1'b0;
    c_rst = 1'b0; loop_en = 1'b0; step = '0;
    mdl_a = mdl_rst(LO_A);
    mdl_b = mdl_rst(LO_B);
    @(negedge clk);
    @(negedge clk);
    chk("reset_a", 0, out_a, {8'd0, 4'b0000});
    chk("reset_b", 0, out_b, {8'd5, 4'b0000});
    reset = 1'b0;

    // Directed table on instance A; instance B tracked by the model.
    foreach (tbl[i]) begin
      drive(tbl[i].tk, tbl[i].rs, tbl[i].fw, tbl[i].bw, tbl[i].pa, tbl[i].pl, tbl[i].lp, tbl[i].st);
      chk("vec_a", i, out_a, {AW'(tbl[i].ea), tbl[i].ep, tbl[i].ed, tbl[i].ew, tbl[i].edn});
      chk("vec_mdl_b", i, out_b, pk(mdl_b));
    end

    // Asynchronous reset between edges while playing backward at addr 11.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_a", 0, out_a, {8'd0, 4'b0000});
    chk("async_rst_b", 0, out_b, {8'd5, 4'b0000});
    mdl_a = mdl_rst(LO_A);
    mdl_b = mdl_rst(LO_B);
    tick = 1'b0; c_play = 1'b0; c_pause = 1'b0; c_fwd = 1'b0; c_bwd = 1'b0;
    c_rst = 1'b0; loop_en = 1'b0; step = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("post_rst_idle_a", k, out_a, {8'd0, 4'b0000});
      chk("post_rst_idle_b", k, out_b, {8'd5, 4'b0000});
    end

    // Random stimulus against the models, with occasional mid-run resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(63) == 0) begin
        reset = 1'b1;
        #1;
        mdl_a = mdl_rst(LO_A);
        mdl_b = mdl_rst(LO_B);
        chk("rnd_rst_a", i, out_a, pk(mdl_a));
        chk("rnd_rst_b", i, out_b, pk(mdl_b));
        @(negedge clk);
        reset = 1'b0;
      end else begin
        drive($urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
              $urandom_range(15) == 0, $urandom_range(11) == 0, $urandom_range(5) == 0,
              $urandom_range(1) == 1, int'($urandom_range(15)));
        chk("rnd_a", i, out_a, pk(mdl_a));
        chk("rnd_b", i, out_b, pk(mdl_b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
